// File: rtl/dmem_responder.sv
// Data-memory responder for the CPU MEM stage.
// Single-port word array behind a request / stall / ack handshake.
module dmem_responder #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        ack_o,
  output logic        err_o
);

  localparam int          WORDS  = 2 ** DEPTH_LOG2;
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [3:0]              cnt_q;
  logic [3:0]              cnt_d;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic                    we_q;
  logic [31:0]             wdata_q;
  logic [31:0]             mem [WORDS];

  logic accept;
  logic aligned;
  logic finish;
  logic unused_addr;

  assign accept      = (state_q == IDLE) && req_i;
  assign aligned     = (addr_i[1:0] == 2'b00);
  assign finish      = (state_q == BUSY) && (cnt_q == 4'd0);
  assign unused_addr = ^addr_i[31:DEPTH_LOG2+2];

  // Freeze the pipeline from accept until the last busy cycle.
  assign stall_o = !rst_i &&
                   (accept || (state_q == BUSY));

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          cnt_d   = LAT_M1;
          state_d = aligned ? BUSY : DONE;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter and registered response outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
      rdata_o <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_o   <= (state_d == DONE);
      err_o   <= accept && !aligned;
      if (accept && !aligned) begin
        rdata_o <= 32'd0;
      end else if (finish && !we_q) begin
        rdata_o <= mem[idx_q];
      end
    end
  end

  // Capture the request so later input changes cannot disturb it.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      idx_q   <= addr_i[DEPTH_LOG2+1:2];
      we_q    <= we_i;
      wdata_q <= wdata_i;
    end
  end

  // Array write on the busy-to-done edge; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i && finish && we_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder.
// Random and directed accesses against a word-array reference model.
module tb_dmem_responder;

  localparam int L = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        ack;
  logic        err;

  logic        req1;
  logic        we1;
  logic [31:0] addr1;
  logic [31:0] wdata1;
  logic [31:0] rdata1;
  logic        stall1;
  logic        ack1;
  logic        err1;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mm [256];
  logic [31:0] exp_rd;

  always #5 clk = ~clk;

  dmem_responder #(
    .DEPTH_LOG2(8),
    .LATENCY   (L)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .req_i  (req),
    .we_i   (we),
    .addr_i (addr),
    .wdata_i(wdata),
    .rdata_o(rdata),
    .stall_o(stall),
    .ack_o  (ack),
    .err_o  (err)
  );

  dmem_responder #(
    .DEPTH_LOG2(8),
    .LATENCY   (1)
  ) dut1 (
    .clk_i  (clk),
    .rst_i  (rst),
    .req_i  (req1),
    .we_i   (we1),
    .addr_i (addr1),
    .wdata_i(wdata1),
    .rdata_o(rdata1),
    .stall_o(stall1),
    .ack_o  (ack1),
    .err_o  (err1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%08h exp=%08h", tag, obs, exp);
    end
  endtask

  // One complete access on the LATENCY=L instance.
  task automatic access(input logic w,
                        input logic [31:0] a,
                        input logic [31:0] d);
    bit al;
    int lat_exp;
    int cyc;
    bit got;
    al      = (a[1:0] == 2'b00);
    lat_exp = al ? L + 2 : 2;
    cyc     = 1;
    got     = 1'b0;
    @(negedge clk);
    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    #1;
    chk("stall_accept", 32'(stall), 32'd1);
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      cyc++;
      if (cyc == 2) begin
        addr  = $urandom;
        wdata = $urandom;
        we    = 1'($urandom);
      end
      #1;
      if (ack) got = 1'b1;
      else chk("stall_busy", 32'(stall), 32'd1);
    end
    chk("ack_seen", 32'(got), 32'd1);
    chk("ack_cycle", 32'(cyc), 32'(lat_exp));
    if (!al) exp_rd = 32'd0;
    else if (w) mm[a[9:2]] = d;
    else exp_rd = mm[a[9:2]];
    chk("err_done", 32'(err), al ? 32'd0 : 32'd1);
    chk("rdata_done", rdata, exp_rd);
    chk("stall_done", 32'(stall), 32'd0);
    req  = 1'b0;
    addr = $urandom;
    @(negedge clk);
    #1;
    chk("ack_idle", 32'(ack), 32'd0);
    chk("err_idle", 32'(err), 32'd0);
    chk("rdata_hold", rdata, exp_rd);
  endtask

  initial begin
    logic [31:0] a;
    rst    = 1'b1;
    req    = 1'b1;
    we     = 1'b0;
    addr   = 32'd0;
    wdata  = 32'd0;
    req1   = 1'b0;
    we1    = 1'b0;
    addr1  = 32'd0;
    wdata1 = 32'd0;
    exp_rd = 32'd0;

    // Reset state, with req held high.
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    req = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("idle_ack", 32'(ack), 32'd0);
    chk("idle_stall", 32'(stall), 32'd0);

    // Preload every word.
    for (int i = 0; i < 256; i++) begin
      access(1'b1, 32'(i) << 2, $urandom);
    end

    // Store then load.
    access(1'b1, 32'h40, 32'hDEADBEEF);
    access(1'b0, 32'h40, 32'h0);

    // Misaligned load clears rdata, array intact.
    access(1'b1, 32'h44, 32'h00001234);
    access(1'b0, 32'h44, 32'h0);
    access(1'b0, 32'h42, 32'h0);
    access(1'b1, 32'h43, 32'h55555555);
    access(1'b0, 32'h40, 32'h0);
    access(1'b0, 32'h43, 32'h0);

    // Address wrap.
    access(1'b1, 32'h400, 32'hA5A5A5A5);
    access(1'b0, 32'h000, 32'h0);
    access(1'b0, 32'hFFFF_FC00, 32'h0);

    // Randomized mix.
    for (int i = 0; i < 200; i++) begin
      a = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
      access(1'($urandom), a, $urandom);
    end

    // Reset during the second busy cycle abandons the store.
    access(1'b0, 32'h80, 32'h0);
    @(negedge clk);
    req   = 1'b1;
    we    = 1'b1;
    addr  = 32'h80;
    wdata = 32'h11111111;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_stall", 32'(stall), 32'd0);
    @(negedge clk);
    #1;
    chk("midrst_ack", 32'(ack), 32'd0);
    chk("midrst_rdata", rdata, 32'd0);
    chk("midrst_stall2", 32'(stall), 32'd0);
    rst = 1'b0;
    req = 1'b0;
    exp_rd = 32'd0;
    @(negedge clk);
    #1;
    chk("postrst_ack", 32'(ack), 32'd0);
    access(1'b0, 32'h80, 32'h0);

    // Back-to-back on the LATENCY=1 instance.
    @(negedge clk);
    req1   = 1'b1;
    we1    = 1'b1;
    addr1  = 32'h8;
    wdata1 = 32'hCAFEF00D;
    for (int c = 1; c <= 7; c++) begin
      #1;
      chk("b2b_ack", 32'(ack1),
          (c == 3 || c == 6) ? 32'd1 : 32'd0);
      chk("b2b_err", 32'(err1), 32'd0);
      if (c == 4) chk("b2b_stall", 32'(stall1), 32'd1);
      if (c == 6) chk("b2b_rdata", rdata1, 32'hCAFEF00D);
      if (c == 3) we1 = 1'b0;
      if (c == 6) req1 = 1'b0;
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_LOG2, default 8: word array holds 2^DEPTH_LOG2 32-bit words.
REQ-002 Parameter LATENCY, default 3, legal range 1..15: number of BUSY cycles per aligned access.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous and active-high.
REQ-005 req_i  input  1  CPU MEM-stage access request; held by the CPU until ack_o.
REQ-006 we_i  input  1  1 = store, 0 = load; sampled with req_i.
REQ-007 addr_i  input  32  byte address.
REQ-008 wdata_i  input  32  store data.
REQ-009 rdata_o  output  32  load data; registered.
REQ-010 stall_o  output  1  pipeline freeze request to the CPU; combinational.
REQ-011 ack_o  output  1  one-cycle completion pulse; registered.
REQ-012 err_o  output  1  misaligned-access flag; valid only while ack_o=1.

Function
REQ-013 The FSM SHALL have three states: IDLE, BUSY, DONE.
REQ-014 In IDLE with req_i=1, the block SHALL latch addr_i, we_i and wdata_i, and load a down-counter with LATENCY-1.
REQ-015 On that same IDLE accept, it SHALL go to BUSY if addr_i[1:0]=00, else to DONE with the error flag set.
REQ-016 In IDLE with req_i=0, the block SHALL remain in IDLE with no state change.
REQ-017 In BUSY, the counter SHALL decrement each cycle; on the cycle it equals 0 the FSM SHALL go to DONE.
REQ-018 Aligned access timing: accepted in cycle T, BUSY for cycles T+1..T+LATENCY, DONE in cycle T+LATENCY+1.
REQ-019 stall_o SHALL equal (IDLE and req_i) or BUSY; stall_o SHALL be 0 in DONE.
REQ-020 ack_o SHALL be 1 exactly during DONE and 0 in every other state.
REQ-021 DONE SHALL always return to IDLE on the next cycle; req_i seen during DONE is the completing request and SHALL be ignored.
REQ-022 Word index SHALL be latched addr[DEPTH_LOG2+1:2]; higher address bits SHALL be ignored, so addresses wrap modulo the array size.
REQ-023 An aligned store SHALL write the latched wdata to the array on the BUSY-to-DONE edge; rdata_o SHALL hold its previous value.
REQ-024 An aligned load SHALL register the array word into rdata_o on the BUSY-to-DONE edge.
REQ-025 rdata_o SHALL hold its value until the next completing load or a reset.
REQ-026 A load immediately following a store to the same word SHALL return the newly stored data.
REQ-027 A misaligned access SHALL set err_o=1 in DONE, SHALL perform no array write, and SHALL clear rdata_o to 0.
REQ-028 err_o SHALL be 0 whenever ack_o=0.
REQ-029 Input changes on addr_i, we_i and wdata_i after accept SHALL have no effect on the access in flight.
REQ-030 Array contents SHALL NOT be reset; the array is initialised only by stores or by bench preload.

Reset
REQ-031 When rst_i=1 at a clock edge, the block SHALL go to IDLE and clear the counter, rdata_o, ack_o and err_o to 0.
REQ-032 While rst_i=1, stall_o SHALL be 0 regardless of req_i.
REQ-033 Reset asserted during BUSY SHALL abandon the access: no array write and no ack_o pulse.
REQ-034 The first request after reset deasserts SHALL be accepted in the first cycle in which rst_i=0 and req_i=1.

Verification
REQ-035 Store then load, LATENCY=3: store 0xDEADBEEF at 0x40 -> stall_o=1 for 4 cycles, ack_o on cycle 5. Then load 0x40 -> ack_o on cycle 5 with rdata_o=0xDEADBEEF.
REQ-036 Misaligned load: load 0x42 with rdata_o previously 0x1234 -> ack_o and err_o=1 on cycle 2, rdata_o=0. A following load of 0x40 still returns the previously stored value.
REQ-037 Address wrap, DEPTH_LOG2=8: store 0xA5A5A5A5 to 0x400 -> a load of 0x000 returns 0xA5A5A5A5.
REQ-038 Reset mid-BUSY: store 0x11111111 to 0x80, assert rst_i during the second BUSY cycle -> no ack_o, stall_o=0. A later load of 0x80 returns the prior contents.
REQ-039 Back-to-back requests with LATENCY=1: req_i held high across two accesses -> ack_o pulses on cycles 3 and 6, with IDLE between them.
REQ-040 Input hold: change addr_i and wdata_i during BUSY -> the write lands at the originally latched address with the originally latched data.
